// File: rtl/page_walker.sv
// page_walker: two-level page-table walker translating a 16-bit VA to a 14-bit PA.
// Issues word reads to the memory controller, checks valid/W/U bits and reports
// either the physical address or a fault code.
// Optional feature: define PTW_TLB_EN to add a one-entry translation cache.
module page_walker #(
  parameter int unsigned READ_LAT = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        in_req,
  input  logic [15:0] in_va,
  input  logic        in_write,
  input  logic        in_user,
  input  logic [7:0]  in_ptbr,
  input  logic        in_flush,
  output logic        out_ready,
  output logic        out_done,
  output logic [13:0] out_pa,
  output logic        out_fault,
  output logic [1:0]  out_fault_code,
  output logic        out_dram_ren,
  output logic [13:0] out_dram_addr,
  output logic [1:0]  out_dram_size,
  input  logic [31:0] in_mcu_data
);

  localparam int unsigned CntW = (READ_LAT < 1) ? 1 : $clog2(READ_LAT + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(READ_LAT);

  typedef enum logic [1:0] {StIdle, StL1Wait, StL2Wait, StDone} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [15:0]     va_q, va_d;
  logic            write_q, write_d;
  logic            user_q, user_d;
  logic [7:0]      ptbr_q, ptbr_d;
  logic [7:0]      l2base_q, l2base_d;
  logic [13:0]     pa_q, pa_d;
  logic            fault_q, fault_d;
  logic [1:0]      code_q, code_d;

  logic sample;
  logic perm_fail;
  logic unused_data;

  assign sample    = (cnt_q == CntLast);
  assign perm_fail = (write_q & ~in_mcu_data[1]) | (user_q & ~in_mcu_data[2]);
  // PTE bits with no meaning in either table format
  assign unused_data = ^{in_mcu_data[31:14], in_mcu_data[5:3]};

`ifdef PTW_TLB_EN
  logic       tlb_valid_q;
  logic [7:0] tlb_tag_q;
  logic [5:0] tlb_ppn_q;
  logic       tlb_w_q, tlb_u_q;
  logic       suppress_q;
  logic       tlb_hit;
  logic       tlb_perm_fail;
  logic       fill;

  // A flush in the same cycle as a lookup wins over the stale entry
  assign tlb_hit       = tlb_valid_q && (tlb_tag_q == in_va[15:8]) && !in_flush;
  assign tlb_perm_fail = (in_write & ~tlb_w_q) | (in_user & ~tlb_u_q);
`else
  logic unused_flush;
  assign unused_flush = in_flush;
`endif

  // State and datapath registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      va_q     <= '0;
      write_q  <= 1'b0;
      user_q   <= 1'b0;
      ptbr_q   <= '0;
      l2base_q <= '0;
      pa_q     <= '0;
      fault_q  <= 1'b0;
      code_q   <= 2'b00;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      va_q     <= va_d;
      write_q  <= write_d;
      user_q   <= user_d;
      ptbr_q   <= ptbr_d;
      l2base_q <= l2base_d;
      pa_q     <= pa_d;
      fault_q  <= fault_d;
      code_q   <= code_d;
    end
  end

  // Walk sequencing, PTE checks and result capture
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    va_d     = va_q;
    write_d  = write_q;
    user_d   = user_q;
    ptbr_d   = ptbr_q;
    l2base_d = l2base_q;
    pa_d     = pa_q;
    fault_d  = fault_q;
    code_d   = code_q;
`ifdef PTW_TLB_EN
    fill     = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (in_req) begin
          va_d    = in_va;
          write_d = in_write;
          user_d  = in_user;
          ptbr_d  = in_ptbr;
          cnt_d   = '0;
`ifdef PTW_TLB_EN
          if (tlb_hit) begin
            state_d = StDone;
            if (tlb_perm_fail) begin
              pa_d    = '0;
              fault_d = 1'b1;
              code_d  = 2'b11;
            end else begin
              pa_d    = {tlb_ppn_q, in_va[7:0]};
              fault_d = 1'b0;
              code_d  = 2'b00;
            end
          end else begin
            state_d = StL1Wait;
          end
`else
          state_d = StL1Wait;
`endif
        end
      end
      StL1Wait: begin
        if (sample) begin
          cnt_d = '0;
          if (!in_mcu_data[0]) begin
            state_d = StDone;
            pa_d    = '0;
            fault_d = 1'b1;
            code_d  = 2'b01;
          end else begin
            state_d  = StL2Wait;
            l2base_d = in_mcu_data[13:6];
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StL2Wait: begin
        if (sample) begin
          cnt_d   = '0;
          state_d = StDone;
          if (!in_mcu_data[0]) begin
            pa_d    = '0;
            fault_d = 1'b1;
            code_d  = 2'b10;
          end else if (perm_fail) begin
            pa_d    = '0;
            fault_d = 1'b1;
            code_d  = 2'b11;
          end else begin
            pa_d    = {in_mcu_data[13:8], va_q[7:0]};
            fault_d = 1'b0;
            code_d  = 2'b00;
`ifdef PTW_TLB_EN
            fill    = 1'b1;
`endif
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

`ifdef PTW_TLB_EN
  // Single-entry cache; a flush seen during a walk blocks that walk's refill
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tlb_valid_q <= 1'b0;
      tlb_tag_q   <= '0;
      tlb_ppn_q   <= '0;
      tlb_w_q     <= 1'b0;
      tlb_u_q     <= 1'b0;
      suppress_q  <= 1'b0;
    end else begin
      if (state_q == StIdle && in_req) begin
        suppress_q <= 1'b0;
      end else if (in_flush) begin
        suppress_q <= 1'b1;
      end
      if (in_flush) begin
        tlb_valid_q <= 1'b0;
      end else if (fill && !suppress_q) begin
        tlb_valid_q <= 1'b1;
        tlb_tag_q   <= va_q[15:8];
        tlb_ppn_q   <= in_mcu_data[13:8];
        tlb_w_q     <= in_mcu_data[1];
        tlb_u_q     <= in_mcu_data[2];
      end
    end
  end
`endif

  // Outputs decoded from state; read address follows the table level
  always_comb begin
    out_ready      = (state_q == StIdle);
    out_done       = (state_q == StDone);
    out_pa         = pa_q;
    out_fault      = fault_q;
    out_fault_code = code_q;
    out_dram_ren   = 1'b0;
    out_dram_addr  = '0;
    out_dram_size  = 2'b00;
    if (state_q == StL1Wait) begin
      out_dram_ren  = 1'b1;
      out_dram_addr = {ptbr_q, va_q[15:12], 2'b00};
      out_dram_size = 2'b10;
    end else if (state_q == StL2Wait) begin
      out_dram_ren  = 1'b1;
      out_dram_addr = {l2base_q, va_q[11:8], 2'b00};
      out_dram_size = 2'b10;
    end
  end

endmodule

// File: tb/tb_page_walker.sv
// Self-checking bench for page_walker with a latency-accurate memory model
// and a table-walk reference model (includes the cache when PTW_TLB_EN is defined).
module tb_page_walker;

  localparam int unsigned READ_LAT = 2;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_req = 1'b0;
  logic [15:0] in_va = '0;
  logic        in_write = 1'b0;
  logic        in_user = 1'b0;
  logic [7:0]  in_ptbr = '0;
  logic        in_flush = 1'b0;
  logic        out_ready, out_done, out_fault, out_dram_ren;
  logic [13:0] out_pa, out_dram_addr;
  logic [1:0]  out_fault_code, out_dram_size;
  logic [31:0] in_mcu_data;

  int n_checks = 0;
  int n_fail = 0;

  logic [31:0] mem [0:4095];

`ifdef PTW_TLB_EN
  bit         m_tlb_v = 1'b0;
  logic [7:0] m_tag = '0;
  logic [5:0] m_ppn = '0;
  bit         m_w = 1'b0;
  bit         m_u = 1'b0;
`endif

  page_walker #(.READ_LAT(READ_LAT)) dut (
    .clock(clock), .reset_n(reset_n), .in_req(in_req), .in_va(in_va),
    .in_write(in_write), .in_user(in_user), .in_ptbr(in_ptbr), .in_flush(in_flush),
    .out_ready(out_ready), .out_done(out_done), .out_pa(out_pa), .out_fault(out_fault),
    .out_fault_code(out_fault_code), .out_dram_ren(out_dram_ren),
    .out_dram_addr(out_dram_addr), .out_dram_size(out_dram_size), .in_mcu_data(in_mcu_data)
  );

  always #5 clock = ~clock;

  // Memory controller: data valid only after READ_LAT sampled cycles at one address
  logic [13:0] last_addr = '0;
  int          run = 0;
  int          eff_run;
  logic [31:0] garbage = '0;
  always @(posedge clock) begin
    garbage <= $urandom;
    if (out_dram_ren) begin
      run       <= ((out_dram_addr == last_addr) ? run : 0) + 1;
      last_addr <= out_dram_addr;
    end else begin
      run <= 0;
    end
  end
  assign eff_run = (out_dram_addr == last_addr) ? run : 0;
  assign in_mcu_data = (out_dram_ren && eff_run >= int'(READ_LAT)) ?
                       mem[out_dram_addr[13:2]] : garbage;

  // Reference translation computed straight from the table formats
  task automatic model(input logic [15:0] va, input logic wr, input logic us,
                       input logic [7:0] ptbr, output logic [1:0] code,
                       output logic [13:0] pa, output int cyc, output int reads,
                       output logic [13:0] l1a, output logic [13:0] l2a, output bit hit);
    logic [31:0] e1, e2;
    hit = 1'b0; pa = '0; l2a = '0; code = 2'd0;
    l1a = {ptbr, va[15:12], 2'b00};
`ifdef PTW_TLB_EN
    if (m_tlb_v && m_tag == va[15:8]) begin
      hit = 1'b1; cyc = 1; reads = 0;
      code = ((wr && !m_w) || (us && !m_u)) ? 2'd3 : 2'd0;
      if (code == 2'd0) pa = {m_ppn, va[7:0]};
      return;
    end
`endif
    e1 = mem[l1a[13:2]];
    if (!e1[0]) begin
      code = 2'd1; cyc = READ_LAT + 2; reads = READ_LAT + 1;
      return;
    end
    l2a = {e1[13:6], va[11:8], 2'b00};
    e2 = mem[l2a[13:2]];
    cyc = 2 * (READ_LAT + 1) + 1; reads = 2 * (READ_LAT + 1);
    if (!e2[0]) code = 2'd2;
    else if ((wr && !e2[1]) || (us && !e2[2])) code = 2'd3;
    else pa = {e2[13:8], va[7:0]};
  endtask

  task automatic do_flush();
    in_flush = 1'b1;
    @(posedge clock); #1;
    in_flush = 1'b0;
`ifdef PTW_TLB_EN
    m_tlb_v = 1'b0;
`endif
  endtask

  // One request: accept, track every cycle to DONE, check result and timing
  task automatic do_req(input logic [15:0] va, input logic wr, input logic us,
                        input logic [7:0] ptbr, input int flush_at);
    logic [1:0]  ecode;
    logic [13:0] epa, l1a, l2a;
    int          ecyc, ereads, n, reads;
    bit          hit, addr_ok, size_ok, got_done, flushed;
    model(va, wr, us, ptbr, ecode, epa, ecyc, ereads, l1a, l2a, hit);
    n_checks++;
    if (out_ready !== 1'b1) begin
      n_fail++; $display("FAIL ready_before_accept: got %b expected 1", out_ready);
    end
    in_req = 1'b1; in_va = va; in_write = wr; in_user = us; in_ptbr = ptbr;
    @(posedge clock); #1;
    in_req = 1'b0; in_va = 16'($urandom); in_write = 1'($urandom);
    in_user = 1'($urandom); in_ptbr = 8'($urandom);
    n_checks++;
    if (out_ready !== 1'b0) begin
      n_fail++; $display("FAIL ready_after_accept: got %b expected 0", out_ready);
    end
    n = 1; reads = 0; addr_ok = 1'b1; size_ok = 1'b1; got_done = 1'b0; flushed = 1'b0;
    while (n <= 40) begin
      in_flush = (n == flush_at);
      if (n == flush_at) flushed = 1'b1;
      if (out_dram_ren === 1'b1) begin
        if (out_dram_addr !== ((reads < int'(READ_LAT) + 1) ? l1a : l2a)) addr_ok = 1'b0;
        if (out_dram_size !== 2'b10) size_ok = 1'b0;
        reads++;
      end else if (out_dram_size !== 2'b00) begin
        size_ok = 1'b0;
      end
      if (out_done === 1'b1) begin
        got_done = 1'b1;
        break;
      end
      @(posedge clock); #1;
      n++;
    end
    n_checks++;
    if (!got_done) begin
      n_fail++; $display("FAIL done_timeout: va=%h no out_done within 40 cycles", va);
    end else begin
      if (n != ecyc) begin
        n_fail++; $display("FAIL done_cycle: va=%h got %0d expected %0d hit=%0b", va, n, ecyc, hit);
      end
      n_checks++;
      if (reads != ereads) begin
        n_fail++; $display("FAIL read_cycles: va=%h got %0d expected %0d", va, reads, ereads);
      end
      n_checks++;
      if (!addr_ok) begin
        n_fail++; $display("FAIL read_addr: va=%h got wrong address expected l1=%h l2=%h", va, l1a, l2a);
      end
      n_checks++;
      if (!size_ok) begin
        n_fail++; $display("FAIL read_size: va=%h got wrong size expected 2 while ren else 0", va);
      end
    end
    @(posedge clock); #1;
    in_flush = 1'b0;
    n_checks++;
    if (out_done !== 1'b0 || out_ready !== 1'b1) begin
      n_fail++; $display("FAIL after_done: got done=%b ready=%b expected 0/1", out_done, out_ready);
    end
    n_checks++;
    if (out_fault !== (ecode != 2'd0) || out_fault_code !== ecode) begin
      n_fail++; $display("FAIL fault: va=%h got %b/%b expected %b/%b",
                         va, out_fault, out_fault_code, ecode != 2'd0, ecode);
    end
    if (ecode == 2'd0) begin
      n_checks++;
      if (out_pa !== epa) begin
        n_fail++; $display("FAIL pa: va=%h got %h expected %h", va, out_pa, epa);
      end
    end
`ifdef PTW_TLB_EN
    begin
      logic [31:0] e2;
      if (flushed) begin
        m_tlb_v = 1'b0;
      end else if (!hit && ecode == 2'd0) begin
        e2 = mem[l2a[13:2]];
        m_tlb_v = 1'b1; m_tag = va[15:8]; m_ppn = e2[13:8]; m_w = e2[1]; m_u = e2[2];
      end
    end
`endif
  endtask

  task automatic check_idle_outputs(input string name);
    n_checks++;
    if (out_ready !== 1'b1 || out_done !== 1'b0 || out_pa !== 14'd0 || out_fault !== 1'b0 ||
        out_fault_code !== 2'd0 || out_dram_ren !== 1'b0 || out_dram_addr !== 14'd0 ||
        out_dram_size !== 2'd0) begin
      n_fail++;
      $display("FAIL %s: got rdy=%b done=%b pa=%h f=%b c=%b ren=%b addr=%h sz=%b expected 1,0,0...",
               name, out_ready, out_done, out_pa, out_fault, out_fault_code, out_dram_ren,
               out_dram_addr, out_dram_size);
    end
  endtask

  task automatic test_reset();
    #2;
    check_idle_outputs("reset_state");
    #20 reset_n = 1'b1;
    @(posedge clock); #1;
    check_idle_outputs("after_reset_release");
  endtask

  task automatic test_valid_walk();
    mem[12'h103] = 32'h0000_0801;   // L1 entry at 0x40C -> L2 base 0x20
    mem[12'h205] = 32'h0000_0F07;   // L2 entry at 0x814: PPN 0x0F, W, U
    do_req(16'h35AB, 1'b0, 1'b0, 8'h10, 0);
  endtask

  task automatic test_faults();
    mem[12'h109] = 32'h0000_0FFE;   // VA 0x9xxx: L1 invalid
    do_req(16'h9123, 1'b0, 1'b0, 8'h10, 0);
    mem[12'h10A] = 32'h0000_08C1;   // VA 0xA3xx: L2 at 0x8CC invalid
    mem[12'h233] = 32'h0000_3F06;
    do_req(16'hA3C4, 1'b0, 1'b0, 8'h10, 0);
  endtask

  task automatic test_permissions();
    mem[12'h105] = 32'h0000_0841;   // VA 0x57xx -> L2 at 0x85C: W=0 U=1
    mem[12'h217] = 32'h0000_1205;
    do_req(16'h5766, 1'b1, 1'b0, 8'h10, 0);
    do_req(16'h5766, 1'b0, 1'b0, 8'h10, 0);
    mem[12'h106] = 32'h0000_0881;   // VA 0x6Cxx -> L2 at 0x8B0: W=1 U=0
    mem[12'h22C] = 32'h0000_2A03;
    do_req(16'h6C01, 1'b0, 1'b1, 8'h10, 0);
  endtask

  task automatic test_tlb();
    do_flush();
    do_req(16'h35AB, 1'b0, 1'b0, 8'h10, 0);
    do_req(16'h35AB, 1'b0, 1'b0, 8'h10, 0);
    do_req(16'h3510, 1'b1, 1'b1, 8'h10, 0);
    do_flush();
    do_req(16'h35AB, 1'b0, 1'b0, 8'h10, 0);
    do_req(16'h5766, 1'b0, 1'b0, 8'h10, 3);  // flush mid-walk blocks refill
    do_req(16'h5766, 1'b0, 1'b0, 8'h10, 0);
  endtask

  task automatic test_back_to_back();
    do_req(16'h5701, 1'b0, 1'b1, 8'h10, 0);
    do_req(16'h6CFF, 1'b1, 1'b0, 8'h10, 0);
    do_req(16'h35AB, 1'b0, 1'b0, 8'h10, 0);
  endtask

  task automatic test_reset_mid_walk();
    do_flush();
    in_req = 1'b1; in_va = 16'h35AB; in_write = 1'b0; in_user = 1'b0; in_ptbr = 8'h10;
    @(posedge clock); #1;
    in_req = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    n_checks++;
    if (out_dram_ren !== 1'b1 || out_dram_addr !== 14'h0814) begin
      n_fail++; $display("FAIL l2_wait_read: got ren=%b addr=%h expected 1/0814",
                         out_dram_ren, out_dram_addr);
    end
    reset_n = 1'b0;
    #1;
    check_idle_outputs("reset_mid_walk");
`ifdef PTW_TLB_EN
    m_tlb_v = 1'b0;
`endif
    @(posedge clock); #3;
    reset_n = 1'b1;
    @(posedge clock); #1;
    check_idle_outputs("after_mid_reset");
    do_req(16'h35AB, 1'b0, 1'b0, 8'h10, 0);
  endtask

  task automatic test_random();
    logic [15:0] pool [6];
    logic [7:0]  ptbr;
    logic [31:0] w;
    int          fa;
    for (int i = 0; i < 4096; i++) begin
      w = $urandom;
      w[0] = ($urandom_range(0, 3) != 0);
      mem[i] = w;
    end
    ptbr = 8'($urandom);
    for (int i = 0; i < 6; i++) pool[i] = 16'($urandom);
    do_flush();
    repeat (40) begin
      fa = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 7)) : 0;
      do_req(pool[$urandom_range(0, 5)], 1'($urandom), 1'($urandom), ptbr, fa);
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = $urandom;
    test_reset();
    test_valid_walk();
    test_faults();
    test_permissions();
    test_tlb();
    test_back_to_back();
    test_reset_mid_walk();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
